// File: rtl/sat_pkg.sv
// Shared SAT-engine constants: literal encoding, loader error codes and FSM states.
package sat_pkg;

  localparam logic [1:0] LIT_NONE = 2'b00;
  localparam logic [1:0] LIT_POS  = 2'b01;
  localparam logic [1:0] LIT_NEG  = 2'b10;
  localparam logic [1:0] LIT_ILL  = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] ERR_EMPTY    = 2'd2;
  localparam logic [1:0] ERR_READBACK = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_CHECK,
    ST_CLEAR,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/clause_lit_check.sv
// Combinational clause sanity check: any illegal literal, or no literal present at all.
module clause_lit_check
  import sat_pkg::*;
#(
  parameter int unsigned NUM_LITS = 8
) (
  input  logic [NUM_LITS*2-1:0] lits,
  output logic                  illegal_c,
  output logic                  empty_c
);

  // Scan every 2-bit literal field
  always_comb begin
    illegal_c = 1'b0;
    empty_c   = 1'b1;
    for (int i = 0; i < int'(NUM_LITS); i++) begin
      if (lits[2*i +: 2] == LIT_ILL)  illegal_c = 1'b1;
      if (lits[2*i +: 2] != LIT_NONE) empty_c   = 1'b0;
    end
  end

endmodule

// File: rtl/clause_loader.sv
// Loads clauses from the host stream into a clause-array bank, verifies each row
// by readback and zero-fills the unused rows.
module clause_loader
  import sat_pkg::*;
#(
  parameter int unsigned NUM_LITS    = 8,
  parameter int unsigned NUM_CLAUSES = 8,
  parameter int unsigned WIDTH_CNT   = $clog2(NUM_CLAUSES + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  input  logic [WIDTH_CNT-1:0]              num_clauses_i,
  input  logic                              clause_valid_i,
  output logic                              clause_ready_o,
  input  logic [NUM_LITS*2-1:0]             clause_lits_i,
  output logic [NUM_CLAUSES-1:0]            wr_o,
  output logic [NUM_LITS*2-1:0]             lit_o,
  input  logic [NUM_CLAUSES*NUM_LITS*2-1:0] lit_rd_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o,
  output logic [1:0]                        err_code_o
);

  localparam int unsigned LW = NUM_LITS * 2;

  loader_state_t          state_q;
  logic [WIDTH_CNT-1:0]   cnt_q;
  logic [WIDTH_CNT-1:0]   row_q;
  logic [LW-1:0]          lits_q;
  logic [WIDTH_CNT-1:0]   cnt_clamp_c;
  logic [WIDTH_CNT-1:0]   row_nxt_c;
  logic [LW-1:0]          rd_row_c;
  logic                   illegal_c;
  logic                   empty_c;

  clause_lit_check #(.NUM_LITS(NUM_LITS)) u_check (
    .lits      (clause_lits_i),
    .illegal_c (illegal_c),
    .empty_c   (empty_c)
  );

  assign cnt_clamp_c = (num_clauses_i > WIDTH_CNT'(NUM_CLAUSES)) ? WIDTH_CNT'(NUM_CLAUSES)
                                                                 : num_clauses_i;
  assign row_nxt_c   = row_q + WIDTH_CNT'(1);

  // Select the readback word of the row currently being verified
  always_comb begin
    rd_row_c = '0;
    for (int r = 0; r < int'(NUM_CLAUSES); r++) begin
      if (row_q == WIDTH_CNT'(r)) rd_row_c = lit_rd_i[r*LW +: LW];
    end
  end

  // Loader FSM; every output is set up one cycle ahead so it lines up with its state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      row_q          <= '0;
      lits_q         <= '0;
      clause_ready_o <= 1'b0;
      wr_o           <= '0;
      lit_o          <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      err_code_o     <= ERR_NONE;
    end else begin
      done_o <= 1'b0;
      wr_o   <= '0;
      lit_o  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cnt_q      <= cnt_clamp_c;
            row_q      <= '0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
            busy_o     <= 1'b1;
            if (cnt_clamp_c == '0) begin
              state_q <= ST_CLEAR;
              wr_o    <= NUM_CLAUSES'(1);
            end else begin
              state_q        <= ST_LOAD;
              clause_ready_o <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (clause_valid_i && clause_ready_o) begin
            clause_ready_o <= 1'b0;
            lits_q         <= clause_lits_i;
            if (illegal_c) begin
              err_o      <= 1'b1;
              err_code_o <= ERR_ILLEGAL;
              done_o     <= 1'b1;
              state_q    <= ST_DONE;
            end else if (empty_c) begin
              err_o      <= 1'b1;
              err_code_o <= ERR_EMPTY;
              done_o     <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              wr_o    <= NUM_CLAUSES'(1) << row_q;
              lit_o   <= clause_lits_i;
              state_q <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (rd_row_c != lits_q) begin
            err_o      <= 1'b1;
            err_code_o <= ERR_READBACK;
            done_o     <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            row_q <= row_nxt_c;
            if (row_nxt_c == cnt_q) begin
              wr_o    <= NUM_CLAUSES'(1) << row_nxt_c;
              state_q <= ST_CLEAR;
            end else begin
              clause_ready_o <= 1'b1;
              state_q        <= ST_LOAD;
            end
          end
        end
        ST_CLEAR: begin
          lits_q <= '0;
          if (row_q == WIDTH_CNT'(NUM_CLAUSES)) begin
            done_o  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            row_q <= row_nxt_c;
            wr_o  <= NUM_CLAUSES'(1) << row_nxt_c;
          end
        end
        ST_DONE: begin
          busy_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_o         <= 1'b0;
          clause_ready_o <= 1'b0;
          state_q        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
